// File: rtl/ps2key_event_encoder.sv
// ----------------------------------------------------------------------------
// ps2key_event_encoder
//
// Turns a vector of live button levels into ps2_key-style keyboard events,
// one make or break event per toggle of ps2_key[64]. Changes are serialised
// in button-index order. Consecutive events are spaced GAP clocks apart.
//
// Parameters
//   GAP      clocks between consecutive event toggles when backlogged (2..255)
//
// Ports
//   clk_sys  in   1   single clock, rising edge
//   reset    in   1   synchronous, active-high
//   btn_in   in   7   button levels, already synchronous to clk_sys
//                     [0] up [1] down [2] left [3] right
//                     [4] fire [5] start 1P [6] coin
//   ps2_key  out  65  [7:0] scancode, [15:8] F0/E0/00, [23:16] E0/00,
//                     [63:24] zero, [64] toggles once per event
//   busy     out  1   an event is pending or the gap timer is running
// ----------------------------------------------------------------------------
module ps2key_event_encoder #(
    parameter int unsigned GAP = 16
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [6:0]  btn_in,
    output logic [64:0] ps2_key,
    output logic        busy
);

    typedef enum logic {
        IDLE,
        HOLD
    } state_e;

    state_e      state_q;
    logic [6:0]  btn_q;
    logic [6:0]  sent_q;      // level last reported per button
    logic [7:0]  cnt_q;
    logic [6:0]  pending;
    logic [2:0]  sel_idx;
    logic [6:0]  sent_flip;
    logic [63:0] word_d;      // event word for the selected button

    // Buttons 0..3 (the arrows) use E0-prefixed extended codes.
    function automatic logic [7:0] scancode(input logic [2:0] idx);
        case (idx)
            3'd0:    return 8'h75;
            3'd1:    return 8'h72;
            3'd2:    return 8'h6B;
            3'd3:    return 8'h74;
            3'd4:    return 8'h29;
            3'd5:    return 8'h05;
            default: return 8'h04;
        endcase
    endfunction

    // A button that changes and returns before service drops out of pending,
    // which is what cancels glitches.
    assign pending = btn_q ^ sent_q;
    assign busy    = (state_q == HOLD) | (|pending);

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch
        // is inferred when nothing is pending.
        sel_idx = 3'd0;
        // Scan downwards so the lowest set index is the one left standing.
        for (int i = 6; i >= 0; i--) begin
            if (pending[i]) begin
                sel_idx = 3'(i);
            end
        end
        sent_flip = 7'b1 << sel_idx;

        word_d       = '0;
        word_d[7:0]  = scancode(sel_idx);
        if (!btn_q[sel_idx]) begin
            word_d[15:8] = 8'hF0;
            if (!sel_idx[2]) begin
                word_d[23:16] = 8'hE0;
            end
        end else if (!sel_idx[2]) begin
            word_d[15:8] = 8'hE0;
        end
    end

    // HOLD lasts GAP-1 clocks (cnt counts GAP-2 down to 0), and the return to
    // IDLE costs one more, so back-to-back toggles land exactly GAP apart.
    always_ff @(posedge clk_sys) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (reset) begin
            state_q <= IDLE;
            btn_q   <= '0;
            sent_q  <= '0;
            cnt_q   <= '0;
            ps2_key <= '0;
        end else begin
            btn_q <= btn_in;
            case (state_q)
                IDLE: begin
                    if (|pending) begin
                        sent_q  <= sent_q ^ sent_flip;
                        // All 65 bits move on the same edge, so a consumer
                        // keyed on bit 64 always sees a coherent word.
                        ps2_key <= {~ps2_key[64], word_d};
                        cnt_q   <= 8'(GAP - 2);
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (cnt_q == 8'd0) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2key_event_encoder.sv
// ----------------------------------------------------------------------------
// tb_ps2key_event_encoder
//
// Directed stimulus pushes the expected event (code and edge number) into a
// queue; an independent monitor pops and compares on every bit-64 toggle.
// A second instance with GAP=4 feeds a small keyboard-decoder model for the
// random round-trip.
// ----------------------------------------------------------------------------
module tb_ps2key_event_encoder;

    localparam int GAP    = 16;
    localparam int GAP_RT = 4;

    typedef struct {
        logic [23:0] code;
        int          at;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  btn = '0;
    logic [6:0]  btn_rt = '0;
    logic [64:0] key;
    logic [64:0] key_rt;
    logic        busy;
    logic        busy_rt;

    int          cyc = 0;
    logic        rst_at_edge = 1'b1;
    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail = 0;
    logic [6:0]  dec = '0;
    logic [7:0]  codes [7] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h29, 8'h05, 8'h04};

    ps2key_event_encoder #(.GAP(GAP)) u_dut (
        .clk_sys (clk),
        .reset   (reset),
        .btn_in  (btn),
        .ps2_key (key),
        .busy    (busy)
    );

    ps2key_event_encoder #(.GAP(GAP_RT)) u_rt (
        .clk_sys (clk),
        .reset   (reset),
        .btn_in  (btn_rt),
        .ps2_key (key_rt),
        .busy    (busy_rt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= reset;
    end

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [23:0] code, input int at);
        exp_t e;
        e.code = code;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard monitor for the GAP=16 instance.
    initial begin
        logic prev64;
        exp_t e;
        prev64 = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_at_edge) begin
                prev64 = key[64];
            end else if (key[64] !== prev64) begin
                prev64 = key[64];
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_event: got %h at cycle %0d, expected none",
                             key[63:0], cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("event_word", {1'b0, key[63:0]}, {41'd0, e.code});
                    check("event_cycle", 65'(cyc), 65'(e.at));
                end
            end
        end
    end

    // Keyboard-decoder model for the round-trip instance.
    initial begin
        logic prev64;
        logic found;
        int   idx;
        logic ext;
        logic rel;
        prev64 = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_at_edge) begin
                prev64 = key_rt[64];
                dec    = '0;
            end else if (key_rt[64] !== prev64) begin
                prev64 = key_rt[64];
                found  = 1'b0;
                idx    = 0;
                for (int i = 0; i < 7; i++) begin
                    if (codes[i] == key_rt[7:0]) begin
                        found = 1'b1;
                        idx   = i;
                    end
                end
                ext = (key_rt[15:8] == 8'hE0) || (key_rt[23:16] == 8'hE0);
                rel = (key_rt[15:8] == 8'hF0);
                check("rt_code_known", 65'(found), 65'(1));
                check("rt_extended", 65'(ext), 65'(idx < 4));
                check("rt_upper_zero", 65'(key_rt[63:24]), 65'(0));
                if (found) begin
                    dec[idx] = ~rel;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: got no completion by cycle %0d, expected finish", cyc);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int hold;

        // Reset state.
        step(3);
        reset = 1'b0;
        check("reset_key", key, 65'd0);
        check("reset_busy", 65'(busy), 65'(0));

        // 1: plain make/break (fire).
        btn = 7'h10;
        push(24'h000029, cyc + 2);
        step(2);
        check("t1_make_word", key, {1'b1, 64'h29});
        check("t1_busy", 65'(busy), 65'(1));
        step(20);
        btn = 7'h00;
        push(24'h00F029, cyc + 2);
        step(2);
        check("t1_break_word", key, {1'b0, 64'h00F029});
        step(20);

        // 2: extended make/break (up).
        btn = 7'h01;
        push(24'h00E075, cyc + 2);
        step(2);
        check("t2_make_word", key, {1'b1, 64'hE075});
        step(20);
        btn = 7'h00;
        push(24'hE0F075, cyc + 2);
        step(2);
        check("t2_break_word", key, {1'b0, 64'hE0F075});
        step(20);

        // 3: all seven at once, serialised in index order GAP apart.
        t0  = cyc;
        btn = 7'h7F;
        push(24'h00E075, t0 + 2);
        push(24'h00E072, t0 + 2 + 1 * GAP);
        push(24'h00E06B, t0 + 2 + 2 * GAP);
        push(24'h00E074, t0 + 2 + 3 * GAP);
        push(24'h000029, t0 + 2 + 4 * GAP);
        push(24'h000005, t0 + 2 + 5 * GAP);
        push(24'h000004, t0 + 2 + 6 * GAP);
        step(2 + 6 * GAP);
        check("t3_last_word", key, {1'b1, 64'h04});
        step(GAP - 2);
        check("t3_busy_held", 65'(busy), 65'(1));
        step(2);
        check("t3_busy_drop", 65'(busy), 65'(0));
        t0  = cyc;
        btn = 7'h00;
        push(24'hE0F075, t0 + 2);
        push(24'hE0F072, t0 + 2 + 1 * GAP);
        push(24'hE0F06B, t0 + 2 + 2 * GAP);
        push(24'hE0F074, t0 + 2 + 3 * GAP);
        push(24'h00F029, t0 + 2 + 4 * GAP);
        push(24'h00F005, t0 + 2 + 5 * GAP);
        push(24'h00F004, t0 + 2 + 6 * GAP);
        step(2 + 6 * GAP + 20);
        check("t3_release_word", key, {1'b0, 64'h00F004});

        // 4: coin glitch inside the fire HOLD window is never reported.
        t0  = cyc;
        btn = 7'h10;
        push(24'h000029, t0 + 2);
        step(4);
        btn = 7'h50;
        step(3);
        btn = 7'h10;
        step(30);
        check("t4_single_toggle", key, {1'b1, 64'h29});
        check("t4_idle", 65'(busy), 65'(0));
        btn = 7'h00;
        push(24'h00F029, cyc + 2);
        step(22);

        // 5: reset mid-HOLD with up held.
        t0  = cyc;
        btn = 7'h01;
        push(24'h00E075, t0 + 2);
        step(5);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("t5_reset_key", key, 65'd0);
        push(24'h00E075, cyc + 2);
        step(1);
        check("t5_key_after", key, 65'd0);
        check("t5_busy_after", 65'(busy), 65'(1));
        step(1);
        check("t5_fresh_make", key, {1'b1, 64'hE075});
        step(20);
        btn = 7'h00;
        push(24'hE0F075, cyc + 2);
        step(22);

        // 6: random round-trip through the decoder model, GAP=4.
        t0 = cyc;
        while (cyc < t0 + 10000) begin
            btn_rt = 7'($urandom);
            hold   = $urandom_range(1, 60);
            step(hold);
            if (hold >= 34) begin
                check("rt_decoded", 65'(dec), 65'(btn_rt));
                check("rt_idle", 65'(busy_rt), 65'(0));
            end
        end
        btn_rt = 7'h00;
        step(40);
        check("rt_final_release", 65'(dec), 65'(0));

        check("queue_empty", 65'(exp_q.size()), 65'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
